// File: rtl/signals_sequencer.sv
// Per-lane engine sequencer: turns software start/soft-reset vectors into launch pulses,
// tracks run/done/timeout per lane, and raises a single irq pulse on lane completion.
module signals_sequencer #(
  parameter int N_LANES = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [31:0]        reset_vec,
  input  logic [31:0]        start_vec,
  input  logic [N_LANES-1:0] eng_done,
  output logic [N_LANES-1:0] eng_start,
  output logic [N_LANES-1:0] eng_rst,
  output logic [N_LANES-1:0] busy,
  output logic [N_LANES-1:0] done,
  output logic [N_LANES-1:0] timeout,
  output logic [31:0]        status,
  output logic               irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_TOUT
  } lane_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  logic [N_LANES-1:0] start_q;
  logic [N_LANES-1:0] lane_enter;

  // Vector bits above the lane count are intentionally ignored.
  logic unused_hi;
  assign unused_hi = ^{reset_vec, start_vec};

  // start_q keeps tracking through soft reset so a held start bit cannot relaunch.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      start_q <= '0;
      eng_rst <= '0;
      irq     <= 1'b0;
    end else begin
      start_q <= start_vec[N_LANES-1:0];
      eng_rst <= reset_vec[N_LANES-1:0];
      irq     <= |lane_enter;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rise;
    logic             enter;

    assign rise = start_vec[i] & ~start_q[i];

    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      enter    = 1'b0;
      if (reset_vec[i]) begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) state_nx = S_LAUNCH;
          end
          S_LAUNCH: begin
            cnt_nx   = '0;
            state_nx = S_RUN;
          end
          S_RUN: begin
            if (cnt != CNT_MAX) cnt_nx = cnt + CNT_W'(1);
            // Completion takes priority over a coincident terminal count.
            if (eng_done[i]) begin
              state_nx = S_DONE;
              enter    = 1'b1;
            end else if (TO_EN && (cnt == CNT_TC)) begin
              state_nx = S_TOUT;
              enter    = 1'b1;
            end
          end
          S_DONE, S_TOUT: begin
            if (!start_vec[i]) state_nx = S_IDLE;
          end
          default: state_nx = S_IDLE;
        endcase
      end
    end

    assign lane_enter[i] = enter;
    assign eng_start[i]  = (state == S_LAUNCH);
    assign busy[i]       = (state == S_LAUNCH) || (state == S_RUN);
    assign done[i]       = (state == S_DONE);
    assign timeout[i]    = (state == S_TOUT);
  end

  always_comb begin
    status                   = '0;
    status[N_LANES-1:0]      = done;
    status[16 +: N_LANES]    = timeout;
  end

endmodule

// File: tb/tb_signals_sequencer.sv
// Bench for signals_sequencer: directed scenarios plus randomized traffic compared
// against a lane-age reference model.
module tb_signals_sequencer;
  localparam int NL = 4;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   reset_vec, start_vec;
  logic [NL-1:0] eng_done;
  logic [NL-1:0] eng_start, eng_rst, busy, done, timeout;
  logic [31:0]   status;
  logic          irq;

  int errors = 0;
  int checks = 0;

  signals_sequencer #(.N_LANES(NL), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .reset_vec(reset_vec), .start_vec(start_vec),
    .eng_done(eng_done), .eng_start(eng_start), .eng_rst(eng_rst), .busy(busy),
    .done(done), .timeout(timeout), .status(status), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: age -1 = idle, 0 = launch cycle, n>=1 = n-th run cycle.
  int m_age [NL];
  bit m_fd  [NL];
  bit m_ft  [NL];
  bit m_sq  [NL];
  bit m_rst [NL];
  bit m_irq;

  initial begin
    for (int i = 0; i < NL; i++) begin
      m_age[i] = -1; m_fd[i] = 0; m_ft[i] = 0; m_sq[i] = 0; m_rst[i] = 0;
    end
    m_irq = 0;
  end

  always @(posedge HCLK) begin : model
    bit ev;
    bit st;
    ev = 0;
    for (int i = 0; i < NL; i++) begin
      if (HRESET) begin
        m_age[i] = -1; m_fd[i] = 0; m_ft[i] = 0; m_sq[i] = 0; m_rst[i] = 0;
      end else begin
        st = start_vec[i];
        if (reset_vec[i]) begin
          m_age[i] = -1; m_fd[i] = 0; m_ft[i] = 0;
        end else if (m_fd[i] || m_ft[i]) begin
          if (!st) begin m_fd[i] = 0; m_ft[i] = 0; end
        end else if (m_age[i] < 0) begin
          if (st && !m_sq[i]) m_age[i] = 0;
        end else if (m_age[i] == 0) begin
          m_age[i] = 1;
        end else if (eng_done[i]) begin
          m_fd[i] = 1; m_age[i] = -1; ev = 1;
        end else if (TO != 0 && m_age[i] == TO) begin
          m_ft[i] = 1; m_age[i] = -1; ev = 1;
        end else begin
          m_age[i] = m_age[i] + 1;
        end
        m_sq[i]  = st;
        m_rst[i] = reset_vec[i];
      end
    end
    m_irq = HRESET ? 1'b0 : ev;
  end

  function automatic logic [NL-1:0] exp_start();
    for (int i = 0; i < NL; i++) exp_start[i] = (m_age[i] == 0);
  endfunction
  function automatic logic [NL-1:0] exp_busy();
    for (int i = 0; i < NL; i++) exp_busy[i] = (m_age[i] >= 0);
  endfunction
  function automatic logic [NL-1:0] exp_done();
    for (int i = 0; i < NL; i++) exp_done[i] = m_fd[i];
  endfunction
  function automatic logic [NL-1:0] exp_tout();
    for (int i = 0; i < NL; i++) exp_tout[i] = m_ft[i];
  endfunction
  function automatic logic [NL-1:0] exp_rst();
    for (int i = 0; i < NL; i++) exp_rst[i] = m_rst[i];
  endfunction

  task automatic test_reset();
    HRESET = 1; reset_vec = '0; start_vec = '0; eng_done = '0;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 0;
    checks++;
    if ({eng_start, eng_rst, busy, done, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_lanes: got %h expected 0", {eng_start, eng_rst, busy, done, timeout});
    end
    checks++;
    if (status !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h expected 00000000", status);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_normal();
    @(negedge HCLK) start_vec = 32'h1;
    @(negedge HCLK);
    checks++;
    if (eng_start !== 4'b0001 || busy !== 4'b0001) begin
      errors++; $display("FAIL norm_launch: got start=%b busy=%b expected 0001/0001", eng_start, busy);
    end
    @(negedge HCLK);
    checks++;
    if (eng_start !== 4'b0000 || busy !== 4'b0001) begin
      errors++; $display("FAIL norm_start_once: got start=%b busy=%b expected 0000/0001", eng_start, busy);
    end
    repeat (3) @(negedge HCLK);
    eng_done = 4'b0001;
    @(negedge HCLK) eng_done = '0;
    checks++;
    if (done !== 4'b0001 || status !== 32'h1 || irq !== 1'b1) begin
      errors++; $display("FAIL norm_done: got done=%b status=%h irq=%b expected 0001/00000001/1", done, status, irq);
    end
    @(negedge HCLK);
    checks++;
    if (irq !== 1'b0 || done !== 4'b0001) begin
      errors++; $display("FAIL norm_irq_pulse: got irq=%b done=%b expected 0/0001", irq, done);
    end
    start_vec = '0;
    @(negedge HCLK);
    checks++;
    if (done !== 4'b0000 || busy !== 4'b0000) begin
      errors++; $display("FAIL norm_rearm: got done=%b busy=%b expected 0000/0000", done, busy);
    end
  endtask

  task automatic test_timeout();
    int irqs = 0;
    int early = 0;
    @(negedge HCLK) start_vec = 32'h4;
    for (int c = 0; c <= 8; c++) begin
      @(negedge HCLK);
      if (c == 0) begin
        checks++;
        if (eng_start !== 4'b0100) begin
          errors++; $display("FAIL to_launch: got %b expected 0100", eng_start);
        end
      end
      if (timeout !== 4'b0000) early++;
      if (irq) irqs++;
    end
    checks++;
    if (early != 0 || irqs != 0) begin
      errors++; $display("FAIL to_early: got early=%0d irqs=%0d expected 0/0", early, irqs);
    end
    @(negedge HCLK);
    checks++;
    if (timeout !== 4'b0100 || status !== 32'h0004_0000 || irq !== 1'b1 || busy !== 4'b0000) begin
      errors++; $display("FAIL to_flag: got to=%b status=%h irq=%b busy=%b expected 0100/00040000/1/0000",
                         timeout, status, irq, busy);
    end
    @(negedge HCLK);
    checks++;
    if (irq !== 1'b0 || timeout !== 4'b0100) begin
      errors++; $display("FAIL to_sticky: got irq=%b to=%b expected 0/0100", irq, timeout);
    end
    start_vec = '0;
    @(negedge HCLK);
    checks++;
    if (timeout !== 4'b0000) begin
      errors++; $display("FAIL to_clear: got %b expected 0000", timeout);
    end
  endtask

  task automatic test_tie();
    @(negedge HCLK) start_vec = 32'h2;
    repeat (9) @(negedge HCLK);
    eng_done = 4'b0010;
    @(negedge HCLK) eng_done = '0;
    checks++;
    if (done !== 4'b0010 || timeout !== 4'b0000 || irq !== 1'b1) begin
      errors++; $display("FAIL tie: got done=%b to=%b irq=%b expected 0010/0000/1", done, timeout, irq);
    end
    start_vec = '0;
    @(negedge HCLK);
    checks++;
    if (done !== 4'b0000) begin
      errors++; $display("FAIL tie_clear: got %b expected 0000", done);
    end
  endtask

  task automatic test_soft_reset();
    logic [NL-1:0] seen = '0;
    int irqs = 0;
    @(negedge HCLK) start_vec = 32'h8;
    repeat (3) @(negedge HCLK);
    checks++;
    if (busy !== 4'b1000) begin
      errors++; $display("FAIL srst_busy: got %b expected 1000", busy);
    end
    reset_vec = 32'h8;
    @(negedge HCLK);
    checks++;
    if (eng_rst !== 4'b1000 || busy !== 4'b0000 || irq !== 1'b0) begin
      errors++; $display("FAIL srst_apply: got rst=%b busy=%b irq=%b expected 1000/0000/0", eng_rst, busy, irq);
    end
    @(negedge HCLK) reset_vec = '0;
    repeat (5) begin
      @(negedge HCLK);
      seen |= eng_start;
      if (irq) irqs++;
    end
    checks++;
    if (seen !== 4'b0000 || irqs != 0 || done !== 4'b0000 || timeout !== 4'b0000) begin
      errors++; $display("FAIL srst_norelaunch: got start=%b irqs=%0d done=%b to=%b expected 0000/0/0000/0000",
                         seen, irqs, done, timeout);
    end
    start_vec = '0;
    @(negedge HCLK) start_vec = 32'h8;
    @(negedge HCLK);
    checks++;
    if (eng_start !== 4'b1000) begin
      errors++; $display("FAIL srst_retoggle: got %b expected 1000", eng_start);
    end
    reset_vec = 32'h8; start_vec = '0;
    @(negedge HCLK) reset_vec = '0;
    @(negedge HCLK);
  endtask

  task automatic test_back_to_back();
    logic [NL-1:0] seen = '0;
    @(negedge HCLK) start_vec = 32'h3;
    @(negedge HCLK);
    checks++;
    if (eng_start !== 4'b0011) begin
      errors++; $display("FAIL b2b_launch: got %b expected 0011", eng_start);
    end
    repeat (2) @(negedge HCLK);
    eng_done = 4'b0011;
    @(negedge HCLK) eng_done = '0;
    checks++;
    if (irq !== 1'b1 || status !== 32'h3) begin
      errors++; $display("FAIL b2b_done: got irq=%b status=%h expected 1/00000003", irq, status);
    end
    @(negedge HCLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL b2b_single_irq: got %b expected 0", irq);
    end
    eng_done = 4'b0011;
    repeat (5) begin
      @(negedge HCLK);
      seen |= eng_start;
    end
    eng_done = '0;
    checks++;
    if (seen !== 4'b0000 || done !== 4'b0011 || irq !== 1'b0) begin
      errors++; $display("FAIL b2b_ignore: got start=%b done=%b irq=%b expected 0000/0011/0", seen, done, irq);
    end
    start_vec = '0;
    @(negedge HCLK);
    checks++;
    if (done !== 4'b0000) begin
      errors++; $display("FAIL b2b_clear: got %b expected 0000", done);
    end
  endtask

  task automatic test_random();
    logic [NL-1:0] st = '0;
    logic [31:0]   exp_status;
    for (int c = 0; c < 2000; c++) begin
      @(negedge HCLK);
      exp_status = '0;
      exp_status[NL-1:0]  = exp_done();
      exp_status[16 +: NL] = exp_tout();
      checks++;
      if (eng_start !== exp_start() || busy !== exp_busy() || done !== exp_done() ||
          timeout !== exp_tout() || eng_rst !== exp_rst()) begin
        errors++;
        $display("FAIL rand_lanes c=%0d: got s=%b b=%b d=%b t=%b r=%b expected s=%b b=%b d=%b t=%b r=%b",
                 c, eng_start, busy, done, timeout, eng_rst,
                 exp_start(), exp_busy(), exp_done(), exp_tout(), exp_rst());
      end
      checks++;
      if (status !== exp_status || irq !== m_irq) begin
        errors++;
        $display("FAIL rand_status c=%0d: got status=%h irq=%b expected %h/%b", c, status, irq, exp_status, m_irq);
      end
      HRESET = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 7) == 0) st[i] = ~st[i];
        reset_vec[i] = ($urandom_range(0, 24) == 0);
        eng_done[i]  = ($urandom_range(0, 9) == 0);
      end
      start_vec = {$urandom, st};
      start_vec[31:NL] = $urandom;
      start_vec[NL-1:0] = st;
      reset_vec[31:NL] = $urandom;
    end
    HRESET = 0; reset_vec = '1; start_vec = '0; eng_done = '0;
    @(negedge HCLK) reset_vec = '0;
    @(negedge HCLK);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_tie();
    test_soft_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signals_sequencer.md
Name: signals_sequencer

Overview:
- Sits directly downstream of the AHB control-register slave.
- Consumes its 32-bit reset and start vectors and converts them into per-lane engine control: one-cycle start pulses, soft-reset levels, busy, done and timeout tracking.
- Returns a packed status word for the finished readback path.
- Produces an interrupt pulse when a lane completes or times out.

Parameters:
N_LANES, 4, number of engine lanes driven; legal range 1..16; vector bits >= N_LANES ignored
CNT_W, 16, width of per-lane run-cycle counter
TIMEOUT, 1000, RUN cycles before a lane is declared timed out; 0 disables timeout

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESET  in  1  synchronous, active-high reset
reset_vec  in  32  soft-reset vector from register slave; bit i = lane i
start_vec  in  32  start vector from register slave; bit i = lane i, level written by software
eng_done  in  N_LANES  engine completion, level or pulse, sampled only in RUN
eng_start  out  N_LANES  one-cycle launch pulse per lane
eng_rst  out  N_LANES  per-lane engine reset, registered copy of reset_vec[i]
busy  out  N_LANES  lane in LAUNCH or RUN
done  out  N_LANES  lane in DONE
timeout  out  N_LANES  lane in TOUT
status  out  32  {timeout bits at [16+N_LANES-1:16], done bits at [N_LANES-1:0]}, all other bits 0
irq  out  1  one-cycle pulse on any lane entering DONE or TOUT

Behaviour:
- Per-lane FSM with states IDLE, LAUNCH, RUN, DONE, TOUT. Each lane has an independent CNT_W counter and a start_q register for edge detection.
- HRESET (sync): all lanes go to IDLE; counters, start_q, eng_rst, irq and all outputs become 0.
- rise[i] = start_vec[i] & ~start_q[i]. start_q[i] <= start_vec[i] every cycle, including during soft reset.
- A start_vec bit already high when HRESET releases counts as a rise.
- IDLE -> LAUNCH on rise[i]; a rise in any other state is ignored.
- LAUNCH: eng_start[i]=1 for exactly this one cycle; counter cleared; always -> RUN.
- Latency: rise sampled at edge k; eng_start high in cycle k..k+1; RUN from edge k+1.
- eng_done is ignored while in LAUNCH.
- RUN: counter increments each cycle.
  - eng_done[i]=1 -> DONE.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1 -> TOUT.
  - eng_done wins over a simultaneous terminal count.
- DONE / TOUT: sticky. -> IDLE only when start_vec[i]==0, so software clears its start bit to re-arm. A new rise requires start to go 0 then 1.
- Soft reset has the highest per-lane priority. While reset_vec[i]=1 the lane is forced to IDLE next edge and its counter cleared. eng_done and rise are ignored while reset_vec[i]=1.
- eng_rst[i] follows reset_vec[i] with one cycle latency.
- A start bit held high through soft reset does not relaunch on release, because start_q keeps tracking.
- Soft reset mid-RUN: busy drops the cycle after reset_vec is sampled; no irq; no done or timeout flag is set.
- Outputs busy, done, timeout and status are Moore decodes of registered state.
- irq is registered: high one cycle after the edge at which any lane enters DONE or TOUT. Multiple lanes entering in the same cycle produce a single pulse.
- Counter never wraps; it saturates at its max value when TIMEOUT=0.

Test Plan:
- Global reset: HRESET=1 for 2 cycles, with start_vec=0 after release -> all outputs 0, status=0x00000000, irq=0.
- Normal run, lane 0: start_vec=0x1 at edge k -> eng_start[0] pulses once in cycle k+1; busy[0]=1. eng_done[0]=1 at cycle k+6 -> done[0]=1 and status=0x00000001 from the next edge; irq pulses once. start_vec=0 -> done[0]=0 next cycle.
- Timeout, TIMEOUT=8, lane 2: start_vec=0x4, eng_done held 0 -> timeout[2]=1 exactly 9 cycles after eng_start[2]; status=0x00040000; irq single pulse.
- Done/terminal-count tie, TIMEOUT=8: eng_done[1] asserted on the cycle the counter reaches 7 -> done[1]=1, timeout[1]=0.
- Soft reset mid-RUN, lane 3: reset_vec=0x8 while busy[3]=1, start_vec held 0x8 -> eng_rst[3]=1 one cycle later; busy[3]=0; no irq. reset_vec=0 -> no relaunch (eng_start[3] stays 0) until start_vec toggles 0 -> 1.
- Simultaneous lanes plus retrigger: start_vec 0x0 -> 0x3 -> eng_start=2'b11 same cycle. Both eng_done asserted the same cycle -> one irq pulse; status=0x00000003. A second rise on lane 0 while in DONE without clearing start is ignored.
